accel_mem_responder: RTL



---
 rtl/accel_mem_responder_if.sv | 26 ++
 rtl/accel_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/accel_mem_responder_if.sv
// Request/response bus between an accelerator datapath (master) and the
// memory responder (slave). Requests carry a bank select plus a 16-bit
// address; responses return read data with a one-cycle valid strobe.
interface accel_mem_responder_if;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic        re;
        logic [4:0]  bank_sel;
    } mem_req_t;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } mem_resp_t;

    mem_req_t  req;
    mem_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/accel_mem_responder.sv
// Memory-side responder for the accelerator request bus: a NUM_BANKS x DEPTH
// x 8-bit BRAM array with pipelined reads, single-cycle writes, sticky error
// flags and saturating access counters.
// Optional macro ACCEL_MEM_ZEROIZE_EN: after reset, sweep every address of
// every bank to zero before accepting requests.
module accel_mem_responder #(
    parameter int unsigned NUM_BANKS = 19,
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned AW        = 11,
    parameter int unsigned OUT_REG   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    accel_mem_responder_if.slave        bus,
    output logic [7:0]                  err_flags,
    input  logic                        err_clr,
    output logic [15:0]                 rd_count,
    output logic [15:0]                 wr_count
);

    localparam int unsigned BW = $clog2(NUM_BANKS);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  sweep_q, sweep_d;
    logic           sweep_we;
    logic           ready;

    logic [7:0]     mem [NUM_BANKS][DEPTH];

    logic           req_valid, bank_bad, addr_bad, dual_bad, legal;
    logic           accept, wr_en, rd_fire;

    logic           s1_valid_q;
    logic [7:0]     s1_data_q;
    logic           out_valid;
    logic [7:0]     out_data;

    logic [3:0]     err_q, err_new;
    logic [15:0]    rd_count_q, wr_count_q;

    // Request decode; all legality checks are independent so several flags can fire at once.
    assign req_valid = bus.req.we | bus.req.re;
    assign bank_bad  = 32'(bus.req.bank_sel) >= NUM_BANKS;
    assign addr_bad  = |bus.req.addr[15:AW];
    assign dual_bad  = bus.req.we & bus.req.re;
    assign legal     = ~bank_bad & ~addr_bad & ~dual_bad;
    assign accept    = req_valid & ready;
    assign wr_en     = accept & bus.req.we & legal;
    assign rd_fire   = accept & bus.req.re;

    // State register; reset lands in INIT only when the zeroize sweep is built in.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef ACCEL_MEM_ZEROIZE_EN
            state_q <= StInit;
`else
            state_q <= StRun;
`endif
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Next-state and ready: INIT walks one address per cycle, RUN accepts requests.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        sweep_we = 1'b0;
        ready    = 1'b0;
        unique case (state_q)
            StInit: begin
`ifdef ACCEL_MEM_ZEROIZE_EN
                sweep_we = ~rst;
                sweep_d  = sweep_q + 1'b1;
                if (sweep_q == AW'(DEPTH - 1)) begin
                    state_d = StRun;
                end
`else
                state_d = StRun;
`endif
            end
            StRun: begin
                ready = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Memory writes: the sweep clears one address in every bank, otherwise one legal write.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                mem[BW'(b)][sweep_q] <= 8'h00;
            end
        end else if (wr_en && !rst) begin
            mem[bus.req.bank_sel][bus.req.addr[AW-1:0]] <= bus.req.data;
        end
    end

    // Read stage 1: synchronous array read; illegal reads still produce a zero beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= 8'h00;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= legal ? mem[bus.req.bank_sel][bus.req.addr[AW-1:0]] : 8'h00;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic       out_valid_q;
            logic [7:0] out_data_q;

            // Optional output register adds one cycle of read latency.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= 8'h00;
                end else begin
                    out_valid_q <= s1_valid_q;
                    out_data_q  <= s1_data_q;
                end
            end

            assign out_valid = out_valid_q;
            assign out_data  = out_data_q;
        end else begin : g_no_out_reg
            assign out_valid = s1_valid_q;
            assign out_data  = s1_data_q;
        end
    endgenerate

    assign bus.resp = {out_data, out_valid, ready};

    // Sticky error flags; a new error in the clear cycle wins over the clear.
    assign err_new = {req_valid & ~ready,
                      req_valid & dual_bad,
                      req_valid & addr_bad,
                      req_valid & bank_bad};

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 4'h0;
        end else begin
            err_q <= (err_clr ? 4'h0 : err_q) | err_new;
        end
    end

    assign err_flags = {4'h0, err_q};

    // Saturating counts of accepted legal reads and writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
        end else begin
            if (rd_fire && legal && rd_count_q != 16'hFFFF) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (wr_en && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule
